// File: rtl/heap_pkg.sv
// Shared types and default widths for the heap arbiter slice.
// Included first so the arbiter and its picker agree on state encoding and index width.
package heap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } heap_arb_state_t;

    localparam int unsigned HEAP_NREQ_DEFAULT  = 2;
    localparam int unsigned HEAP_NHEAP_DEFAULT = 12;
    localparam int unsigned HEAP_WIDTH_DEFAULT = 12;

    // Requester index width; a single requester still needs one bit to hold an index.
    function automatic int unsigned heap_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/heap_rr_picker.sv
// Combinational round-robin picker: scans requesters starting just after the last winner.
// Reports whether anyone is requesting and the index of the first one found.
module heap_rr_picker
    import heap_pkg::*;
#(
    parameter int unsigned NReq = HEAP_NREQ_DEFAULT,
    parameter int unsigned IdxW = heap_idx_width(NReq)
) (
    input  logic [NReq-1:0] req,
    input  logic [IdxW-1:0] last,
    output logic            any,
    output logic [IdxW-1:0] winner
);

    int unsigned idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 1; i <= NReq; i++) begin
            idx = (32'(last) + i) % NReq;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one synchronous heapMemory between NReq requesters.
// Each access runs IDLE -> ACCESS -> CAPTURE; the response pulse returns read or written data.
module heap_arbiter
    import heap_pkg::*;
#(
    parameter int unsigned NReq               = HEAP_NREQ_DEFAULT,
    parameter int unsigned NHeap              = HEAP_NHEAP_DEFAULT,
    parameter int unsigned MemoryElementWidth = HEAP_WIDTH_DEFAULT
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NReq-1:0]                    req,
    input  logic [NReq-1:0]                    reqWrite,
    input  logic [NReq*NHeap-1:0]              reqAddress,
    input  logic [NReq*MemoryElementWidth-1:0] reqIn,
    output logic [NReq-1:0]                    grant,
    output logic [NReq-1:0]                    rspValid,
    output logic [MemoryElementWidth-1:0]      rspOut,
    output logic                               busy,
    output logic                               heapWrite,
    output logic [NHeap-1:0]                   heapAddress,
    output logic [MemoryElementWidth-1:0]      heapIn,
    input  logic [MemoryElementWidth-1:0]      heapOut
);

    localparam int unsigned IdxW = heap_idx_width(NReq);

    heap_arb_state_t              state;
    logic [IdxW-1:0]              last;
    logic [NReq-1:0]              owner;
    logic                         pick_any;
    logic [IdxW-1:0]              pick_idx;
    logic [NReq-1:0]              pick_oh;
    logic [NHeap-1:0]             sel_addr;
    logic [MemoryElementWidth-1:0] sel_in;
    logic                         sel_write;

    heap_rr_picker #(
        .NReq (NReq),
        .IdxW (IdxW)
    ) u_picker (
        .req    (req),
        .last   (last),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // Mux the winner's request fields with constant slices only.
    always_comb begin
        pick_oh   = '0;
        sel_addr  = '0;
        sel_in    = '0;
        sel_write = 1'b0;
        for (int unsigned r = 0; r < NReq; r++) begin
            if (pick_idx == IdxW'(r)) begin
                pick_oh[r] = 1'b1;
                sel_addr   = reqAddress[r*NHeap +: NHeap];
                sel_in     = reqIn[r*MemoryElementWidth +: MemoryElementWidth];
                sel_write  = reqWrite[r];
            end
        end
    end

    // Owner is kept one-hot so the response pulse needs no decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= '0;
            rspValid    <= '0;
            rspOut      <= '0;
            busy        <= 1'b0;
            heapWrite   <= 1'b0;
            heapAddress <= '0;
            heapIn      <= '0;
            last        <= IdxW'(NReq - 1);
            owner       <= '0;
        end else begin
            grant    <= '0;
            rspValid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        heapAddress <= sel_addr;
                        heapIn      <= sel_in;
                        heapWrite   <= sel_write;
                        grant       <= pick_oh;
                        owner       <= pick_oh;
                        last        <= pick_idx;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end else begin
                        heapWrite <= 1'b0;
                    end
                end
                ACCESS: begin
                    heapWrite <= 1'b0;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    rspOut   <= heapOut;
                    rspValid <= owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    heapWrite <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
